// File: rtl/mac_pkg.sv
// ============================================================================
// mac_pkg : shared types for the MAC-filter ingress arbiter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

   localparam int c_DATA_W_DEFAULT = 32;
   localparam int c_MAX_PORTS      = 4;
   localparam int c_PORT_IDX_W     = $clog2(c_MAX_PORTS);

   typedef logic [c_PORT_IDX_W-1:0] port_idx_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PASS = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// ============================================================================
// rr_select : combinational round-robin picker, search starts at last_grant+1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select
   import mac_pkg::*;
#(
   parameter int N_PORTS = 2
) (
   input  logic [N_PORTS-1:0] i_req,
   input  logic [N_PORTS-1:0] i_en,
   input  port_idx_t          i_last_grant,
   output logic               o_valid,
   output port_idx_t          o_idx
);

   logic [N_PORTS-1:0] w_elig;
   logic [N_PORTS-1:0] w_rot;
   int                 w_off;

   assign w_elig = i_req & i_en;

   // Bit k of w_rot is the port k+1 positions after the last grant.
   assign w_rot = N_PORTS'({w_elig, w_elig} >> (int'(i_last_grant) + 1));

   always_comb begin
      o_valid = |w_rot;
      w_off   = 0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = k;
         end
      end
      o_idx = port_idx_t'((int'(i_last_grant) + 1 + w_off) % N_PORTS);
   end

endmodule

`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
// ============================================================================
// axis_pkt_arbiter : packet-atomic round-robin AXI-Stream merge, zero data regs
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_arbiter
   import mac_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int DATA_W  = c_DATA_W_DEFAULT,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_PORTS-1:0]         s_axis_tvalid,
   output logic [N_PORTS-1:0]         s_axis_tready,
   input  logic [N_PORTS*DATA_W-1:0]  s_axis_tdata,
   input  logic [N_PORTS-1:0]         s_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [DATA_W-1:0]          m_axis_tdata,
   output logic                       m_axis_tlast,
   input  logic [N_PORTS-1:0]         port_en,
   output logic [$clog2(N_PORTS)-1:0] grant_id,
   output logic                       busy,
   output logic [N_PORTS*CNT_W-1:0]   pkt_cnt
);

   localparam int c_IDX_W = $clog2(N_PORTS);

   state_t    r_state;
   state_t    w_state_nxt;
   port_idx_t r_grant;
   port_idx_t r_last_grant;
   port_idx_t w_sel_idx;
   logic      w_sel_valid;
   logic      w_done;

   rr_select #(
      .N_PORTS (N_PORTS)
   ) u_rr_select (
      .i_req        (s_axis_tvalid),
      .i_en         (port_en),
      .i_last_grant (r_last_grant),
      .o_valid      (w_sel_valid),
      .o_idx        (w_sel_idx)
   );

   // Datapath is a pure mux on the granted port; nothing is registered.
   always_comb begin
      w_state_nxt   = r_state;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sel_valid) begin
               w_state_nxt = PASS;
            end
         end
         PASS: begin
            for (int i = 0; i < N_PORTS; i++) begin
               if (r_grant == port_idx_t'(i)) begin
                  m_axis_tvalid    = s_axis_tvalid[i];
                  m_axis_tdata     = s_axis_tdata[i*DATA_W +: DATA_W];
                  m_axis_tlast     = s_axis_tlast[i];
                  s_axis_tready[i] = m_axis_tready;
               end
            end
            w_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
            if (w_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_grant <= port_idx_t'(N_PORTS - 1);
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == IDLE) && w_sel_valid) begin
            r_grant <= w_sel_idx;
         end
         if (w_done) begin
            r_last_grant <= r_grant;
         end
      end
   end

   for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_done && (r_grant == port_idx_t'(gi))) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end

      assign pkt_cnt[gi*CNT_W +: CNT_W] = r_cnt;
   end

   // Port index type is sized for the largest configuration.
   if (c_IDX_W < c_PORT_IDX_W) begin : g_idx_pad
      logic w_grant_hi_unused;
      assign w_grant_hi_unused = |r_grant[c_PORT_IDX_W-1:c_IDX_W];
   end

   assign grant_id = r_grant[c_IDX_W-1:0];
   assign busy     = (r_state == PASS);

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
// ============================================================================
// tb_axis_pkt_arbiter : scoreboard bench for axis_pkt_arbiter (2 ports)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_pkt_arbiter;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        tv0 = 1'b0, tv1 = 1'b0, tl0 = 1'b0, tl1 = 1'b0;
   logic [31:0] td0 = '0, td1 = '0;
   logic [1:0]  port_en  = 2'b11;
   logic        m_tready = 1'b1;

   logic [1:0]  s_tready, s_tready2;
   logic        m_tvalid, m_tvalid2, m_tlast, m_tlast2;
   logic [31:0] m_tdata, m_tdata2;
   logic        grant_id, grant_id2, busy, busy2;
   logic [31:0] pkt_cnt;
   logic [3:0]  pkt_cnt2;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   int          gnt_q[$];

   always #5 clk = ~clk;

   axis_pkt_arbiter #(.N_PORTS(2), .DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid({tv1, tv0}), .s_axis_tready(s_tready),
      .s_axis_tdata({td1, td0}), .s_axis_tlast({tl1, tl0}),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
      .port_en(port_en), .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   axis_pkt_arbiter #(.N_PORTS(2), .DATA_W(32), .CNT_W(2)) dut_w2 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tvalid({tv1, tv0}), .s_axis_tready(s_tready2),
      .s_axis_tdata({td1, td0}), .s_axis_tlast({tl1, tl0}),
      .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata2), .m_axis_tlast(m_tlast2),
      .port_en(port_en), .grant_id(grant_id2), .busy(busy2), .pkt_cnt(pkt_cnt2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic idle_gap(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents a packet beat by beat and queues each beat as expected output.
   task automatic send_pkt(input int p, input int n, input logic [31:0] base);
      int   t;
      logic hs;
      for (int b = 0; b < n; b++) begin
         if (p == 0) begin
            tv0 = 1'b1; td0 = base + 32'(b); tl0 = (b == n - 1);
            exp_q0.push_back({tl0, td0});
         end else begin
            tv1 = 1'b1; td1 = base + 32'(b); tl1 = (b == n - 1);
            exp_q1.push_back({tl1, td1});
         end
         t  = 0;
         hs = 1'b0;
         while (!hs && t < 200) begin
            @(negedge clk);
            hs = (p == 0) ? (tv0 & s_tready[0]) : (tv1 & s_tready[1]);
            @(posedge clk);
            #1;
            t++;
         end
         if (!hs) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout port=%0d beat=%0d", p, b);
         end
      end
      if (p == 0) begin tv0 = 1'b0; tl0 = 1'b0; end
      else        begin tv1 = 1'b0; tl1 = 1'b0; end
   endtask

   // Returns at the negedge preceding the next merged-stream handshake.
   task automatic wait_beat(input string name);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(m_tvalid && m_tready) && t < 200);
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s timeout waiting for beat", name);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks routing rules.
   initial begin : monitor
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        bubble;
      logic [32:0] e;
      int          g;
      prev_stall = 1'b0;
      prev_data  = '0;
      bubble     = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
            bubble     = 1'b0;
         end else begin
            if (bubble) chk("bubble", 64'({busy, m_tvalid}), 64'd0);
            bubble = 1'b0;
            g = int'(grant_id);
            if (busy) chk("tready_route", 64'(s_tready), (g == 0) ? 64'({1'b0, m_tready}) : 64'({m_tready, 1'b0}));
            else      chk("idle_quiet", 64'({s_tready, m_tvalid}), 64'd0);
            if (prev_stall && busy) chk("stall_hold", 64'(m_tdata), 64'(prev_data));
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            if (m_tvalid && m_tready) begin
               if ((g == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL beat_unexpected port=%0d actual=%0h required=none", g, m_tdata);
               end else begin
                  e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  chk("beat", 64'({m_tlast, m_tdata}), 64'(e));
               end
               if (m_tlast) begin
                  bubble = 1'b1;
                  if (gnt_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL grant_unexpected actual=%0d required=none", g);
                  end else begin
                     chk("grant_order", 64'(g), 64'(gnt_q.pop_front()));
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_mvalid_busy_grant", 64'({m_tvalid, busy, grant_id}), 64'd0);
      chk("rst_cnt", 64'(pkt_cnt), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle_gap(1);

      // Single 3-beat packet on port 0, one-cycle request latency
      gnt_q.push_back(0);
      fork
         send_pkt(0, 3, 32'h0000_1000);
         begin
            @(negedge clk);
            chk("lat_idle", 64'({busy, m_tvalid}), 64'd0);
            @(negedge clk);
            chk("lat_pass", 64'({busy, m_tvalid, grant_id}), 64'b110);
         end
      join
      idle_gap(2);
      chk("t1_cnt", 64'(pkt_cnt), {32'd0, 16'd0, 16'd1});

      // Fresh reset, both ports stream 2-beat packets: 0,1,0,1
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
      fork
         begin send_pkt(0, 2, 32'h0000_2000); send_pkt(0, 2, 32'h0000_2100); end
         begin send_pkt(1, 2, 32'h0000_3000); send_pkt(1, 2, 32'h0000_3100); end
      join
      idle_gap(2);
      chk("t2_cnt", 64'(pkt_cnt), {32'd0, 16'd2, 16'd2});

      // Backpressure for 5 cycles mid-packet with port 1 waiting
      gnt_q.push_back(0); gnt_q.push_back(1);
      fork
         send_pkt(0, 4, 32'h0000_4000);
         send_pkt(1, 2, 32'h0000_5000);
         begin
            wait_beat("bp_first");
            @(posedge clk); #1 m_tready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("bp_tready", 64'({s_tready, busy, grant_id}), 64'b0010);
            end
            @(posedge clk); #1 m_tready = 1'b1;
         end
      join
      idle_gap(2);
      chk("t3_cnt", 64'(pkt_cnt), {32'd0, 16'd3, 16'd3});

      // Port 1 disabled while requesting; port 0 disabled mid-packet
      port_en = 2'b01;
      tv1 = 1'b1; td1 = 32'hDEAD_BEEF; tl1 = 1'b1;
      gnt_q.push_back(0);
      fork
         send_pkt(0, 3, 32'h0000_6000);
         begin
            wait_beat("en_first");
            @(posedge clk); #1 port_en[0] = 1'b0;
         end
      join
      idle_gap(4);
      chk("t4_idle", 64'({busy, m_tvalid}), 64'd0);
      chk("t4_cnt", 64'(pkt_cnt), {32'd0, 16'd3, 16'd4});
      tv1 = 1'b0; tl1 = 1'b0;
      port_en = 2'b11;
      idle_gap(1);

      // Reset during beat 2 of 4 on port 0 (last grant was port 0)
      tv0 = 1'b1; td0 = 32'h0000_7000; tl0 = 1'b0;
      exp_q0.push_back({1'b0, 32'h0000_7000});
      wait_beat("rst_first");
      @(posedge clk); #1;
      td0 = 32'h0000_7001;
      m_tready = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tready", 64'({s_tready, s_tready2}), 64'd0);
      chk("arst_mvalid_busy_grant", 64'({m_tvalid, busy, grant_id}), 64'd0);
      chk("arst_cnt", 64'({pkt_cnt2, pkt_cnt}), 64'd0);
      tv0 = 1'b0;
      m_tready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      gnt_q.push_back(0); gnt_q.push_back(1);
      fork
         send_pkt(0, 2, 32'h0000_7100);
         send_pkt(1, 2, 32'h0000_8100);
      join
      idle_gap(2);
      chk("t5_cnt", 64'(pkt_cnt), {32'd0, 16'd1, 16'd1});
      chk("t5_cnt_w2", 64'(pkt_cnt2), 64'b0101);

      // Five packets on port 0: the 2-bit counter wraps to 1
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         gnt_q.push_back(0);
         send_pkt(0, 2, 32'h0000_9000 + 32'(i * 16));
      end
      idle_gap(2);
      chk("wrap_cnt_w2", 64'(pkt_cnt2[1:0]), 64'd1);
      chk("wrap_cnt_w16", 64'(pkt_cnt), {32'd0, 16'd0, 16'd5});
      chk("queues_drained", 64'(exp_q0.size() + exp_q1.size() + gnt_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
- REQ-001: Parameter N_PORTS, default 2 (range 2..4); number of AXI-Stream requester ports feeding the MAC filter.
- REQ-002: Parameter DATA_W, default 32; tdata width on every port.
- REQ-003: Parameter CNT_W, default 16; width of each per-port packet counter.
- REQ-004: clk  input  1  single clock; all logic on the rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: s_axis_tvalid  input  N_PORTS  per-port valid.
- REQ-007: s_axis_tready  output  N_PORTS  per-port ready.
- REQ-008: s_axis_tdata  input  N_PORTS x DATA_W  per-port data.
- REQ-009: s_axis_tlast  input  N_PORTS  per-port end-of-packet.
- REQ-010: m_axis_tvalid / m_axis_tready / m_axis_tdata[DATA_W] / m_axis_tlast  out/in/out/out  merged stream toward mac_filter.
- REQ-011: port_en  input  N_PORTS  per-port arbitration enable (configuration).
- REQ-012: grant_id  output  $clog2(N_PORTS)  index of the currently granted port.
- REQ-013: busy  output  1  high while a packet is being forwarded.
- REQ-014: pkt_cnt  output  N_PORTS x CNT_W  completed packets per port.

Function
- REQ-015: FSM states are IDLE and PASS only.
- REQ-016: In IDLE, all s_axis_tready = 0 and m_axis_tvalid = 0.
- REQ-017: In IDLE, if any port has tvalid=1 and port_en=1, the block selects the first such port searching cyclically from last_grant+1; it registers grant_id and enters PASS on the next edge.
- REQ-018: Latency: 1 cycle from a request seen in IDLE to m_axis_tvalid asserted, with no data registering.
- REQ-019: In PASS, m_axis_tvalid/tdata/tlast equal the granted port's signals combinationally, s_axis_tready[grant] = m_axis_tready, and every other s_axis_tready = 0.
- REQ-020: In PASS, a handshake (m_axis_tvalid & m_axis_tready) with tlast=1 returns the FSM to IDLE, sets last_grant = grant_id, and increments pkt_cnt[grant_id].
- REQ-021: The grant is held until tlast; the arbiter never switches ports mid-packet.
- REQ-022: Deasserting port_en for the granted port mid-packet does not abort the packet; the bit is honoured at the next arbitration.
- REQ-023: A one-cycle IDLE bubble always separates consecutive packets, including when a new request coincides with the tlast handshake.
- REQ-024: pkt_cnt wraps modulo 2^CNT_W with no saturation.
- REQ-025: busy = 1 exactly when the state is PASS.
- REQ-026: Upstream data is never dropped or duplicated; backpressure (m_axis_tready=0) stalls the granted port only.

Reset
- REQ-027: While rst_n=0: state=IDLE, s_axis_tready=0, m_axis_tvalid=0, grant_id=0, busy=0, all pkt_cnt=0, last_grant=N_PORTS-1 (so port 0 wins first).
- REQ-028: Reset asserted mid-packet aborts the transfer immediately; the partial packet is not counted.

Structure
- REQ-029: Package mac_pkg holds the DATA_W default, the FSM state enum (IDLE, PASS) and the port-index typedef.
- REQ-030: Sub-module rr_select is purely combinational: inputs request vector, enable vector and last_grant; outputs a valid flag and the winning index.

Verification
- REQ-031: Port 0 sends a 3-beat packet and port 1 is idle -> m_axis carries 3 beats starting 1 cycle after tvalid, grant_id=0, pkt_cnt[0]=1.
- REQ-032: Both ports request continuously with 2-beat packets -> grants alternate 0,1,0,1 with a 1-cycle bubble between packets; after 4 packets pkt_cnt = {2,2}.
- REQ-033: m_axis_tready held 0 for 5 cycles mid-packet -> s_axis_tready[grant]=0 for those cycles, tdata held, no beat lost, and port 1 tready stays 0.
- REQ-034: port_en[1]=0 while port 1 requests -> port 1 is never granted; port_en[0] cleared mid-packet on port 0 -> that packet completes.
- REQ-035: rst_n pulsed low during beat 2 of 4 -> all outputs return to their reset values asynchronously, pkt_cnt=0, and port 0 wins the next arbitration.
- REQ-036: With CNT_W forced to 2, send 5 packets on port 0 -> pkt_cnt[0] reads 1.
